// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor encodings, FSM states and counter width
package elevator_pkg;
    localparam int CNT_W = 4;
    localparam logic [1:0] FLOOR_A = 2'b00;
    localparam logic [1:0] FLOOR_B = 2'b01;
    localparam logic [1:0] FLOOR_C = 2'b10;
    typedef enum logic [1:0] {IDLE, MOVE, OPEN} state_t;
endpackage

// File: rtl/call_dir_sel.sv
// call_dir_sel: request-here, request-ahead and sweep direction for a given floor
module call_dir_sel
    import elevator_pkg::*;
(
    input  logic [1:0] floor,
    input  logic       dir_up,
    input  logic [2:0] pending,
    output logic       req_here,
    output logic       req_ahead,
    output logic       next_dir_up
);
    logic [2:0] here_m;
    logic [2:0] above_m;
    logic [2:0] below_m;
    // Mask pending calls by position relative to the floor; ends force the sweep to turn
    always_comb begin
        here_m      = 3'b001 << floor;
        above_m     = (floor == FLOOR_A) ? 3'b110 : (floor == FLOOR_B) ? 3'b100 : 3'b000;
        below_m     = (floor == FLOOR_C) ? 3'b011 : (floor == FLOOR_B) ? 3'b001 : 3'b000;
        req_here    = |(pending & here_m);
        req_ahead   = |(pending & (dir_up ? above_m : below_m));
        next_dir_up = (floor == FLOOR_A) ? 1'b1 :
                      (floor == FLOOR_C) ? 1'b0 :
                      req_ahead ? dir_up : ~dir_up;
    end
endmodule

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: call latch, sweep FSM, travel and door dwell timing
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int TRAVEL_TICKS = 2,
    parameter int DWELL_TICKS  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       A_e,
    input  logic       B_e,
    input  logic       C_e,
    input  logic       A_i,
    input  logic       B_i,
    input  logic       C_i,
    input  logic       alarm,
    output logic [1:0] floor,
    output logic       door_closed,
    output logic       moving,
    output logic       dir_up,
    output logic [2:0] pending
);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_TICKS - 1);

    state_t           state, state_nx;
    logic [1:0]       floor_nx, step_floor;
    logic             dir_nx;
    logic [2:0]       pend_nx, calls, clr, here_m, arr_m;
    logic [CNT_W-1:0] tcnt, tcnt_nx, dcnt, dcnt_nx;
    logic             here_req, here_ahead, here_dir;
    logic             arr_req, arr_ahead, arr_dir;

    assign calls       = {C_e | C_i, B_e | B_i, A_e | A_i};
    assign step_floor  = dir_up ? floor + 2'd1 : floor - 2'd1;
    assign here_m      = 3'b001 << floor;
    assign arr_m       = 3'b001 << step_floor;
    assign door_closed = state != OPEN;
    assign moving      = state == MOVE;

    call_dir_sel u_here (
        .floor      (floor),
        .dir_up     (dir_up),
        .pending    (pending),
        .req_here   (here_req),
        .req_ahead  (here_ahead),
        .next_dir_up(here_dir)
    );

    call_dir_sel u_arrive (
        .floor      (step_floor),
        .dir_up     (dir_up),
        .pending    (pending),
        .req_here   (arr_req),
        .req_ahead  (arr_ahead),
        .next_dir_up(arr_dir)
    );

    // Next state, position, direction and counters; clears beat new calls in the latch
    always_comb begin
        state_nx = state;
        floor_nx = floor;
        dir_nx   = dir_up;
        tcnt_nx  = tcnt;
        dcnt_nx  = dcnt;
        clr      = 3'b000;
        case (state)
            IDLE: begin
                if (here_req) begin
                    state_nx = OPEN;
                    clr      = here_m;
                    dcnt_nx  = '0;
                end else if (|pending) begin
                    state_nx = MOVE;
                    dir_nx   = here_dir;
                    tcnt_nx  = '0;
                end
            end
            MOVE: begin
                if (tick) begin
                    if (tcnt == TRAVEL_LAST) begin
                        floor_nx = step_floor;
                        tcnt_nx  = '0;
                        dir_nx   = arr_dir;
                        if (arr_req) begin
                            state_nx = OPEN;
                            clr      = arr_m;
                            dcnt_nx  = '0;
                        end else if (~|pending) begin
                            state_nx = IDLE;
                        end
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end
            OPEN: begin
                clr = here_m;
                if (alarm || |(calls & here_m)) begin
                    dcnt_nx = '0;
                end else if (tick) begin
                    if (dcnt == DWELL_LAST) begin
                        state_nx = IDLE;
                        dcnt_nx  = '0;
                    end else begin
                        dcnt_nx = dcnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        pend_nx = (pending | calls) & ~clr;
    end

    // State and request registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            floor   <= FLOOR_A;
            dir_up  <= 1'b1;
            pending <= 3'b000;
            tcnt    <= '0;
            dcnt    <= '0;
        end else begin
            state   <= state_nx;
            floor   <= floor_nx;
            dir_up  <= dir_nx;
            pending <= pend_nx;
            tcnt    <= tcnt_nx;
            dcnt    <= dcnt_nx;
        end
    end
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb_elevator_call_scheduler: vector table, directed corner sequences and random run against a model
module tb_elevator_call_scheduler;
    localparam int TRAVEL = 2;
    localparam int DWELL  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, A_e, B_e, C_e, A_i, B_i, C_i, alarm;
    logic [1:0] floor;
    logic       door_closed, moving, dir_up;
    logic [2:0] pending;

    int checks = 0;
    int errors = 0;

    int       m_fl, m_st, m_tc, m_dc;
    bit       m_dir;
    bit [2:0] m_pd;

    typedef struct {
        bit       tk;
        bit [2:0] ext;
        bit [2:0] inb;
        bit       al;
        bit [1:0] fl;
        bit       dc;
        bit       mv;
        bit [2:0] pd;
    } vec_t;

    vec_t vecs[11];

    elevator_call_scheduler #(.TRAVEL_TICKS(TRAVEL), .DWELL_TICKS(DWELL)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .A_e        (A_e),
        .B_e        (B_e),
        .C_e        (C_e),
        .A_i        (A_i),
        .B_i        (B_i),
        .C_i        (C_i),
        .alarm      (alarm),
        .floor      (floor),
        .door_closed(door_closed),
        .moving     (moving),
        .dir_up     (dir_up),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sweep rule: stay on course while any call lies beyond, else turn; ends force a turn
    function automatic bit choose(input int fl, input bit d, input bit [2:0] p);
        if (fl == 0) return 1'b1;
        if (fl == 2) return 1'b0;
        for (int f = 0; f < 3; f++)
            if (p[f] && (d ? f > fl : f < fl)) return d;
        return !d;
    endfunction

    task automatic model_reset();
        m_fl = 0; m_st = 0; m_tc = 0; m_dc = 0; m_dir = 1'b1; m_pd = 3'b000;
    endtask

    // Model state: 0 idle, 1 travelling, 2 door open; advanced once per clock edge
    task automatic model_step();
        bit [2:0] btn, clr;
        if (!reset) begin
            model_reset();
        end else begin
            btn = {C_e | C_i, B_e | B_i, A_e | A_i};
            clr = 3'b000;
            if (m_st == 0) begin
                if (m_pd[m_fl]) begin
                    m_st = 2; clr[m_fl] = 1'b1; m_dc = 0;
                end else if (m_pd != 0) begin
                    m_st = 1; m_dir = choose(m_fl, m_dir, m_pd); m_tc = 0;
                end
            end else if (m_st == 1) begin
                if (tick) begin
                    m_tc++;
                    if (m_tc == TRAVEL) begin
                        m_tc = 0;
                        m_fl = m_dir ? m_fl + 1 : m_fl - 1;
                        m_dir = choose(m_fl, m_dir, m_pd);
                        if (m_pd[m_fl]) begin
                            m_st = 2; clr[m_fl] = 1'b1; m_dc = 0;
                        end else if (m_pd == 0) begin
                            m_st = 0;
                        end
                    end
                end
            end else begin
                clr[m_fl] = 1'b1;
                if (alarm || btn[m_fl]) m_dc = 0;
                else if (tick) begin
                    m_dc++;
                    if (m_dc == DWELL) begin
                        m_dc = 0; m_st = 0;
                    end
                end
            end
            m_pd = (m_pd | btn) & ~clr;
        end
    endtask

    task automatic step(input bit tk, input bit [2:0] ext, input bit [2:0] inb, input bit al);
        tick = tk;
        {C_e, B_e, A_e} = ext;
        {C_i, B_i, A_i} = inb;
        alarm = al;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        step(1'b0, 3'b000, 3'b000, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        tick = 0; A_e = 0; B_e = 0; C_e = 0; A_i = 0; B_i = 0; C_i = 0; alarm = 0;
        model_reset();
        vecs[0]  = '{1'b0, 3'b000, 3'b010, 1'b0, 2'd0, 1'b1, 1'b0, 3'b010};
        vecs[1]  = '{1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b1, 1'b1, 3'b010};
        vecs[2]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b1, 1'b1, 3'b010};
        vecs[3]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000};
        vecs[4]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000};
        vecs[5]  = '{1'b0, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000};
        vecs[6]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000};
        vecs[7]  = '{1'b1, 3'b000, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, 3'b000};
        vecs[8]  = '{1'b0, 3'b000, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, 3'b000};
        vecs[9]  = '{1'b1, 3'b001, 3'b000, 1'b0, 2'd1, 1'b1, 1'b0, 3'b001};
        vecs[10] = '{1'b0, 3'b000, 3'b000, 1'b0, 2'd1, 1'b1, 1'b1, 3'b001};
        @(negedge clk);
        do_reset();
        chk("rst_floor", floor, 0);
        chk("rst_door", door_closed, 1);
        chk("rst_moving", moving, 0);
        chk("rst_dir", dir_up, 1);
        chk("rst_pending", pending, 0);

        // B_i call from A: travel, dwell, close
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].tk, vecs[i].ext, vecs[i].inb, vecs[i].al);
            chk($sformatf("vec%0d_floor", i), floor, vecs[i].fl);
            chk($sformatf("vec%0d_door", i), door_closed, vecs[i].dc);
            chk($sformatf("vec%0d_moving", i), moving, vecs[i].mv);
            chk($sformatf("vec%0d_pending", i), pending, vecs[i].pd);
        end

        // En-route stop at B for a call made while moving toward C
        do_reset();
        step(1'b1, 3'b100, 3'b000, 1'b0);
        step(1'b1, 3'b010, 3'b000, 1'b0);
        step(1'b1, 3'b000, 3'b000, 1'b0);
        step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("enroute_floor", floor, 1);
        chk("enroute_door", door_closed, 0);
        chk("enroute_pending", pending, 3'b100);
        repeat (3) step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("enroute_close", door_closed, 1);
        step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("enroute_resume", moving, 1);
        repeat (2) step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("atc_floor", floor, 2);
        chk("atc_door", door_closed, 0);
        chk("atc_pending", pending, 0);

        // Alarm holds the door; close exactly DWELL ticks after release
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'b000, 3'b000, 1'b1);
            chk($sformatf("alarm_hold%0d", i), door_closed, 0);
        end
        repeat (2) step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("alarm_still_open", door_closed, 0);
        step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("alarm_closed", door_closed, 1);

        // From C downward through B without stopping
        chk("atc_dir", dir_up, 0);
        step(1'b1, 3'b001, 3'b000, 1'b0);
        step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("down_moving", moving, 1);
        repeat (2) step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("down_passb_floor", floor, 1);
        chk("down_passb_door", door_closed, 1);
        chk("down_passb_moving", moving, 1);
        repeat (2) step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("down_ata_floor", floor, 0);
        chk("down_ata_door", door_closed, 0);
        chk("down_ata_pending", pending, 0);

        // Repeated re-call at the open floor keeps the door open
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 3'b000, (i % 2 == 0) ? 3'b001 : 3'b000, 1'b0);
            chk($sformatf("recall_door%0d", i), door_closed, 0);
            chk($sformatf("recall_pend%0d", i), pending[0], 0);
        end
        step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("recall_open", door_closed, 0);
        step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("recall_closed", door_closed, 1);

        // Asynchronous reset while moving between B and C
        do_reset();
        step(1'b1, 3'b100, 3'b000, 1'b0);
        step(1'b1, 3'b001, 3'b000, 1'b0);
        repeat (2) step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("mid_floor", floor, 1);
        chk("mid_moving", moving, 1);
        chk("mid_pending", pending, 3'b101);
        reset = 1'b0;
        #1;
        chk("arst_floor", floor, 0);
        chk("arst_pending", pending, 0);
        chk("arst_door", door_closed, 1);
        chk("arst_moving", moving, 0);
        chk("arst_dir", dir_up, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step(1'b1, 3'b000, 3'b000, 1'b0);
        chk("post_floor", floor, 0);
        chk("post_moving", moving, 0);
        chk("post_door", door_closed, 1);
        chk("post_pending", pending, 0);

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 {1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0)},
                 {1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0)},
                 1'($urandom_range(0, 19) == 0));
            chk($sformatf("rand%0d_floor", i), floor, m_fl);
            chk($sformatf("rand%0d_door", i), door_closed, (m_st != 2) ? 1 : 0);
            chk($sformatf("rand%0d_moving", i), moving, (m_st == 1) ? 1 : 0);
            chk($sformatf("rand%0d_dir", i), dir_up, m_dir);
            chk($sformatf("rand%0d_pending", i), pending, m_pd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Sequencing controller for the three-floor elevator (floors A, B, C). Latches external and internal call buttons into a pending-request register and selects the next floor with a direction-preserving sweep. Steps the car one floor per travel interval and runs the door dwell, holding the door open while the overload alarm is active. Sits between the call buttons, the people-counter alarm and the floor/door display path, in the same clock domain as the rest of the system.

## Interface
- TRAVEL_TICKS, 2, ticks needed to move one floor (1..15)
- DWELL_TICKS, 3, ticks the door stays open after the last reason to hold it (1..15)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle time-base enable pulse (1 Hz in system); all counters advance only on tick
- A_e, B_e, C_e  in  1 each  external call buttons, level, active-high
- A_i, B_i, C_i  in  1 each  internal call buttons, level, active-high
- alarm  in  1  overload alarm from people counter; 1 = hold door open
- floor  out  2  current floor: A=2'b00, B=2'b01, C=2'b10; 2'b11 never driven
- door_closed  out  1  1 = door closed, 0 = open
- moving  out  1  1 while in MOVE
- dir_up  out  1  current sweep direction; 1 = toward C
- pending  out  3  latched requests, bit0=A, bit1=B, bit2=C

## Operation
- Request latch: pending[f] is set when either button for floor f is high at a clk edge. Clear for floor f takes priority over set in the same cycle.
- States: IDLE, MOVE, OPEN.
- IDLE: door closed, moving=0.
  - pending[floor]=1 → OPEN; clear pending[floor].
  - Else if any pending bit is set → MOVE. dir_up is kept if any request lies ahead; otherwise it reverses.
  - Else stay in IDLE.
- MOVE: travel counter counts ticks. On the TRAVEL_TICKS-th tick, floor moves ±1 per dir_up and the counter reloads.
  - If pending[new floor]=1 → OPEN; clear that bit. Intermediate calls are served en route.
  - Else, if requests remain ahead, continue.
  - Else, re-evaluate direction exactly as in IDLE.
  - floor never leaves A..C. At A, dir_up is forced to 1; at C, it is forced to 0.
- OPEN: door_closed=0; the dwell counter counts ticks.
  - alarm=1 reloads the dwell counter every cycle; the door stays open indefinitely.
  - A call for the current floor reloads dwell and is absorbed; pending stays 0.
  - When dwell reaches DWELL_TICKS with alarm=0 → IDLE; door_closed=1 in the same cycle.
- Calls for other floors accumulate in every state and never abort travel or dwell.
- Direction selection is a pure function of floor, dir_up and pending.

## Timing
- Reset values:
  - state=IDLE, floor=A (00), dir_up=1
  - door_closed=1, moving=0, pending=000
  - both counters 0
- Button to pending: 1 cycle.
- IDLE decision: 1 cycle after pending is visible. moving rises on the IDLE→MOVE edge.
- Floor update: registered. It occurs on the clk edge where tick is the TRAVEL_TICKS-th tick in MOVE. The OPEN entry (door_closed=0) happens on that same edge when the new floor is pending.
- Door-open duration with alarm=0 and no re-calls: exactly DWELL_TICKS ticks.
- tick held high for several cycles counts once per cycle. The counter logic contains no edge detection on tick.
- Reset mid-operation: all state returns to reset values immediately. Pending calls are lost; the car reports floor A.

## Structure
- Package elevator_pkg holds:
  - floor encodings FLOOR_A/B/C
  - the state enum (IDLE, MOVE, OPEN)
  - counter width constant CNT_W=4
- Sub-module call_dir_sel: combinational.
  - Inputs: floor, dir_up, pending.
  - Outputs: req_here, req_ahead, next_dir_up.
- The top level holds the FSM, counters and request register.

## Test plan
- Reset, B_i pulse at floor A, TRAVEL_TICKS=2 → pending=010 next cycle. After 2 ticks: floor=01 and door_closed=0. Door stays open 3 ticks, then door_closed=1 and pending=000.
- At A, press C_e, then B_e while moving before reaching B → car stops at B (door opens, pending=100), then continues to C; final pending=000.
- Alarm held 10 ticks while in OPEN → door_closed stays 0 throughout. After alarm falls, the door closes exactly 3 ticks later.
- Car at C with dir_up=0; A_e and no other calls → moves down through B without stopping, arriving at A after 4 ticks.
- A_i pressed every 2 ticks while OPEN at A → dwell keeps reloading, door never closes, pending[0] stays 0.
- reset asserted while in MOVE between B and C with pending=101 → floor=00, pending=000, door_closed=1, moving=0 asynchronously; the block stays in IDLE after release.
